// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Debounces the board's push buttons and slide switches before they reach the
// processor system's PIO inputs. Every input bit is first brought into the
// clk_clk domain through a two-flop synchronizer. A per-bit counter then
// requires the synchronized level to differ from the accepted (stable) level
// for DEBOUNCE_CYCLES consecutive cycles before it is accepted. Buttons
// additionally get one-cycle press/release pulses that line up with the
// export update.
//
// Ports
//   clk_clk        in   1   system clock, all state on rising edge
//   reset_reset    in   1   asynchronous active-high reset
//   button_raw     in   2   raw button pins, active-low (0 = pressed)
//   switch_raw     in  10   raw slide-switch pins
//   button_export  out  2   debounced button levels (reset: released = 1)
//   switch_export  out 10   debounced switch levels (reset: 0)
//   button_press   out  2   one-cycle pulse on accepted 1->0 button change
//   button_release out  2   one-cycle pulse on accepted 0->1 button change
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  button_raw,
  input  logic [9:0]  switch_raw,
  output logic [1:0]  button_export,
  output logic [9:0]  switch_export,
  output logic [1:0]  button_press,
  output logic [1:0]  button_release
);

  // Bits [1:0] are the buttons, bits [11:2] are the switches.
  localparam int NB = 12;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Buttons idle released (1), switches idle at 0.
  localparam logic [NB-1:0] RST_VAL  = {10'b00_0000_0000, 2'b11};

  logic [NB-1:0] raw_s;
  logic [NB-1:0] sync1_r;
  logic [NB-1:0] sync2_r;
  logic [NB-1:0] stable_r;
  logic [CW-1:0] cnt_r [NB];
  logic [NB-1:0] accept_s;
  logic [1:0]    press_r;
  logic [1:0]    release_r;

  assign raw_s = {switch_raw, button_raw};

  // Acceptance: the synchronized level has disagreed with stable long enough.
  always_comb begin
    accept_s = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      if ((sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_MAX)) begin
        accept_s[i] = 1'b1;
      end else begin
        accept_s[i] = 1'b0;
      end
    end
  end

  // Synchronizers, per-bit debounce counters, stable levels and edge pulses.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_r   <= RST_VAL;
      sync2_r   <= RST_VAL;
      stable_r  <= RST_VAL;
      press_r   <= 2'b00;
      release_r <= 2'b00;
      for (int i = 0; i < NB; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < NB; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          // Any excursion that returns to the accepted level restarts the count.
          cnt_r[i] <= CNT_ZERO;
        end else if (accept_s[i]) begin
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
      // Pulses are registered on the same edge that updates stable, so they
      // coincide with the new export value. sync2 is the level being loaded.
      press_r   <= accept_s[1:0] & ~sync2_r[1:0];
      release_r <= accept_s[1:0] &  sync2_r[1:0];
    end
  end

  assign button_export  = stable_r[1:0];
  assign switch_export  = stable_r[11:2];
  assign button_press   = press_r;
  assign button_release = release_r;

endmodule
